p2s_rr_arbiter: RTL and testbench
=================================

// Module: p2s_rr_arbiter
// PURPOSE
//  Shares one p2s serializer between M parallel requesters using round-robin arbitration.
//  Accepts one N-bit word from the winning requester and presents it on the serializer's
//  p_data/p_valid/p_ready port. Holds the word until the serializer accepts it.
//  Sits directly upstream of p2s; this block's p_* ports connect 1:1 to the p2s p_* ports.
// PARAMETERS
//  N  8  word width; must equal p2s N
//  M  4  number of requesters, >=1; ID width IDW = (M>1) ? $clog2(M) : 1
// PORTS
//  clk        in   1      rising-edge clock
//  rstn       in   1      asynchronous active-low reset
//  req_data   in   M*N    requester i word at [i*N +: N]
//  req_valid  in   M      requester i holds a word; stays high until req_ready[i]
//  req_ready  out  M      one-hot accept strobe
//  p_data     out  N      word to serializer
//  p_valid    out  1      p_data valid
//  p_ready    in   1      serializer ready (high while p2s is in RX)
//  grant_id   out  IDW    index of requester owning the current word
//  busy       out  1      high when state != IDLE
// BEHAVIOUR
//  Reset (rstn low, async): state=IDLE, ptr=0, p_valid=0, p_data=0, grant_id=0, busy=0.
//   req_ready is all-zero while rstn is low. A word in flight is dropped, not replayed.
//  FSM states: IDLE, SEND (plus HDR when P2S_ARB_HEADER_EN is defined).
//  Winner = first i with req_valid[i], searching ptr, ptr+1, ..., M-1, 0, ..., ptr-1.
//  IDLE: req_ready[winner]=1, combinational, only when some req_valid is high.
//   On that cycle's edge: p_data<=req_data[winner], grant_id<=winner, p_valid<=1, ->SEND.
//   With no valid request: stay in IDLE, req_ready=0.
//  SEND: p_valid=1; p_data and grant_id held stable; req_ready=0.
//   On p_valid&&p_ready: p_valid<=0, ptr<=(grant_id==M-1)?0:grant_id+1, ->IDLE.
//  Latency: request accept -> p_valid is 1 cycle. Minimum spacing between words is 2 cycles
//   (SEND, IDLE).
//  Fairness: a requester holding valid waits at most M-1 grants.
//  Simultaneous requests: lowest index at or after ptr wins; the others keep valid held.
//  Wrap: ptr wraps M-1 -> 0.
//  M=1: ptr constant 0; grant_id constant 0.
//  req_valid dropped without ready: treated as no request (protocol violation; no error flagged).
//  p_ready high while in IDLE: ignored.
//  No combinational path from p_ready to req_ready.
// CONFIGURATION
//  P2S_ARB_HEADER_EN defined:
//   - Each granted word is preceded by a header word: p_data = {zeros, grant_id} (zero-extended to N).
//   - IDLE accept -> HDR (p_valid=1, header).
//   - HDR handshake -> SEND with the latched data word; p_valid stays 1 (no bubble).
//   - SEND handshake -> IDLE, ptr updated.
//   - Data word is latched at accept and held in a separate register during HDR.
//   - Requires N >= IDW.
//  P2S_ARB_HEADER_EN undefined: no HDR state; exactly one serializer word per grant.
// TESTING
//  1 Reset mid-SEND: rstn=0 while p_valid=1 -> p_valid=0, busy=0, req_ready=0 immediately
//    (async); after release, next grant goes to req 0.
//  2 Single requester: req_valid=4'b0100, data 8'h3E, p_ready=1 ->
//    req_ready=4'b0100 for 1 cycle; next cycle p_data=8'h3E, grant_id=2.
//  3 All valid, ptr=0, p_ready=1 -> grant order 0,1,2,3,0; words on p_data in the same order;
//    no requester is granted twice before the others.
//  4 Backpressure: p_ready=0 for 5 cycles in SEND -> p_valid, p_data, grant_id stable;
//    req_ready=0 throughout; completes on the first p_ready=1 cycle.
//  5 Wrap: ptr=3, req_valid=4'b1001 -> req 3 wins; next grant is req 0.
//  6 With P2S_ARB_HEADER_EN, req 1 sends 8'h34 -> p_data 8'h01 then 8'h34 on consecutive
//    handshakes; p_valid stays high between them.
//  All tests: p2s instance attached; checker reassembles serial bits LSB-first and compares
//   against the expected word sequence.

Source files
------------

// File: rtl/p2s_rr_arbiter.sv
// Round-robin front end that funnels M requesters into one p2s serializer port.
// Optional P2S_ARB_HEADER_EN: each granted word is preceded by a {0, grant_id} header word.
module p2s_rr_arbiter #(
  parameter int N = 8,
  parameter int M = 4,
  localparam int IDW = (M > 1) ? $clog2(M) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [M*N-1:0]   req_data,
  input  logic [M-1:0]     req_valid,
  output logic [M-1:0]     req_ready,
  output logic [N-1:0]     p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic [IDW-1:0]   grant_id,
  output logic             busy
);

`ifdef P2S_ARB_HEADER_EN
  typedef enum logic [1:0] {IDLE, HDR, SEND} state_t;
  logic [N-1:0] data_q;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] ptr_nxt;
  logic           found;
  logic [N-1:0]   win_word;

  // Two passes emulate the circular search: indices at/after ptr first, then from 0.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_word = '0;
    for (int i = 0; i < M; i++) begin
      if (!found && req_valid[i] && (i >= int'(ptr))) begin
        found    = 1'b1;
        winner   = IDW'(i);
        win_word = req_data[i*N +: N];
      end
    end
    for (int i = 0; i < M; i++) begin
      if (!found && req_valid[i]) begin
        found    = 1'b1;
        winner   = IDW'(i);
        win_word = req_data[i*N +: N];
      end
    end
  end

  // Depends only on state/ptr/req_valid, so p_ready never reaches req_ready.
  assign req_ready = (rstn && (state == IDLE) && found) ? (M'(1) << winner) : '0;
  assign ptr_nxt   = (grant_id == IDW'(M-1)) ? '0 : grant_id + 1'b1;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      ptr      <= '0;
      p_valid  <= 1'b0;
      p_data   <= '0;
      grant_id <= '0;
`ifdef P2S_ARB_HEADER_EN
      data_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= winner;
            p_valid  <= 1'b1;
`ifdef P2S_ARB_HEADER_EN
            data_q   <= win_word;
            p_data   <= N'(winner);
            state    <= HDR;
`else
            p_data   <= win_word;
            state    <= SEND;
`endif
          end
        end
`ifdef P2S_ARB_HEADER_EN
        HDR: begin
          if (p_ready) begin
            p_data <= data_q;
            state  <= SEND;
          end
        end
`endif
        SEND: begin
          if (p_ready) begin
            p_valid <= 1'b0;
            ptr     <= ptr_nxt;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_rr_arbiter.sv
// Bench for p2s_rr_arbiter: directed scenarios plus randomized traffic against a
// queue-based round-robin model, with a behavioural serializer reassembling words LSB-first.
module tb_p2s_rr_arbiter;
  localparam int N   = 8;
  localparam int M   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [M*N-1:0] req_data;
  logic [M-1:0]   req_valid;
  logic [M-1:0]   req_ready;
  logic [N-1:0]   p_data;
  logic           p_valid;
  logic           p_ready;
  logic [IDW-1:0] grant_id;
  logic           busy;

  logic tb_ready;
  logic ser_mode;
  logic ser_ready;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] acc_q[$];
  logic [N-1:0] ser_q[$];
  logic [N-1:0] exp_q[$];

  always #5 clk = ~clk;

  p2s_rr_arbiter #(.N(N), .M(M)) dut (
    .clk(clk), .rstn(rstn),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready),
    .grant_id(grant_id), .busy(busy)
  );

  assign p_ready = ser_mode ? ser_ready : tb_ready;

  // every word the arbiter hands off
  always @(posedge clk)
    if (rstn && p_valid && p_ready) acc_q.push_back(p_data);

  // p2s stand-in: loads a word when idle, shifts it out LSB-first, reassembles it
  logic [N-1:0] sh;
  logic [N-1:0] asm_w;
  int           cnt = 0;
  assign ser_ready = (cnt == 0);
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= 0;
    else if (cnt == 0) begin
      if (ser_mode && p_valid) begin
        sh  <= p_data;
        cnt <= N;
      end
    end else begin
      asm_w <= {sh[0], asm_w[N-1:1]};
      sh    <= sh >> 1;
      cnt   <= cnt - 1;
      if (cnt == 1) ser_q.push_back({sh[0], asm_w[N-1:1]});
    end
  end

  function automatic void add_exp(input int id, input logic [N-1:0] d);
`ifdef P2S_ARB_HEADER_EN
    exp_q.push_back(N'(id));
`endif
    exp_q.push_back(d);
  endfunction

  function automatic int oh_idx(input logic [M-1:0] v);
    oh_idx = -1;
    for (int i = M-1; i >= 0; i--) if (v[i]) oh_idx = i;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0; req_valid = '0; tb_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle_timeout busy=%b exp=0", name, busy); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0; req_valid = '1; req_data = '1; #1;
    total++; if (p_valid !== 1'b0)  begin bad++; $display("FAIL reset_p_valid got=%b exp=0", p_valid); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (grant_id !== '0)   begin bad++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    total++; if (p_data !== '0)     begin bad++; $display("FAIL reset_p_data got=%h exp=00", p_data); end
    total++; if (req_ready !== '0)  begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    @(negedge clk);
    rstn = 1'b1; req_valid = '0; req_data = '0;
  endtask

  task automatic test_single();
    ser_mode = 1'b0; tb_ready = 1'b1;
    @(negedge clk);
    req_data = '0; req_data[2*N +: N] = 8'h3E; req_valid = 4'b0100; #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_req_ready got=%b exp=0100", req_ready); end
    tb_ready = 1'b0; #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_p_ready_path got=%b exp=0100", req_ready); end
    tb_ready = 1'b1;
    @(negedge clk);
`ifdef P2S_ARB_HEADER_EN
    total++; if (p_data !== 8'h02) begin bad++; $display("FAIL single_header got=%h exp=02", p_data); end
    @(negedge clk);
`endif
    total++; if (p_valid !== 1'b1)   begin bad++; $display("FAIL single_p_valid got=%b exp=1", p_valid); end
    total++; if (p_data !== 8'h3E)   begin bad++; $display("FAIL single_p_data got=%h exp=3e", p_data); end
    total++; if (grant_id !== 2'd2)  begin bad++; $display("FAIL single_grant_id got=%0d exp=2", grant_id); end
    total++; if (req_ready !== '0)   begin bad++; $display("FAIL single_ready_in_send got=%b exp=0000", req_ready); end
    req_valid = '0;
    @(negedge clk);
    total++; if (p_valid !== 1'b0)   begin bad++; $display("FAIL single_done got=%b exp=0", p_valid); end
  endtask

  task automatic test_wrap();
    logic [M-1:0] g;
    int n;
    acc_q.delete(); exp_q.delete();
    add_exp(3, 8'hC3); add_exp(0, 8'h5A);
    tb_ready = 1'b1;
    @(negedge clk);
    req_data = '0; req_data[3*N +: N] = 8'hC3; req_data[0 +: N] = 8'h5A; req_valid = 4'b1001; #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_first got=%b exp=1000", req_ready); end
    g = '0; n = 0;
    while (g == '0 && n < 10) begin @(negedge clk); #1; n++; if (req_ready != '0) g = req_ready; end
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL wrap_second got=%b exp=0001", g); end
    @(negedge clk);
    req_valid = '0;
    wait_idle("wrap");
    total++; if (acc_q.size() != exp_q.size()) begin bad++; $display("FAIL wrap_count got=%0d exp=%0d", acc_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (acc_q[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_word%0d got=%h exp=%h", i, acc_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_round_robin();
    int got[$];
    int n;
    apply_reset();
    acc_q.delete(); exp_q.delete();
    for (int k = 0; k < 5; k++) add_exp(k % M, 8'hA0 + 8'(k % M));
    tb_ready = 1'b1;
    for (int i = 0; i < M; i++) req_data[i*N +: N] = 8'hA0 + 8'(i);
    @(negedge clk);
    req_valid = '1;
    n = 0;
    while (got.size() < 5 && n < 60) begin
      #1;
      if (req_ready != '0) begin
        total++; if (!$onehot(req_ready)) begin bad++; $display("FAIL rr_onehot got=%b", req_ready); end
        got.push_back(oh_idx(req_ready));
      end
      if (got.size() < 5) begin @(negedge clk); n++; end
    end
    @(negedge clk);
    req_valid = '0;
    wait_idle("rr");
    total++; if (got.size() != 5) begin bad++; $display("FAIL rr_grants got=%0d exp=5", got.size()); end
    else for (int k = 0; k < 5; k++) begin
      total++; if (got[k] != k % M) begin bad++; $display("FAIL rr_order%0d got=%0d exp=%0d", k, got[k], k % M); end
    end
    total++; if (acc_q.size() != exp_q.size()) begin bad++; $display("FAIL rr_count got=%0d exp=%0d", acc_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (acc_q[i] !== exp_q[i]) begin bad++; $display("FAIL rr_word%0d got=%h exp=%h", i, acc_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [N-1:0] stall_word;
`ifdef P2S_ARB_HEADER_EN
    stall_word = 8'h01;
`else
    stall_word = 8'h77;
`endif
    tb_ready = 1'b0;
    @(negedge clk);
    req_data[1*N +: N] = 8'h77; req_valid = 4'b0010; #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_accept got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (p_valid !== 1'b1 || p_data !== stall_word || grant_id !== 2'd1 || req_ready !== '0) begin
        bad++;
        $display("FAIL bp_stall%0d got v=%b d=%h id=%0d rdy=%b exp v=1 d=%h id=1 rdy=0000",
                 c, p_valid, p_data, grant_id, req_ready, stall_word);
      end
      @(negedge clk);
    end
    tb_ready = 1'b1; req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 10);
`ifdef P2S_ARB_HEADER_EN
    total++; if (n != 2) begin bad++; $display("FAIL bp_release got=%0d exp=2", n); end
`else
    total++; if (n != 1) begin bad++; $display("FAIL bp_release got=%0d exp=1", n); end
`endif
    total++; if (acc_q.size() == 0 || acc_q[acc_q.size()-1] !== 8'h77) begin bad++; $display("FAIL bp_word got=%0d words exp last=77", acc_q.size()); end
  endtask

  task automatic test_reset_mid_send();
    tb_ready = 1'b0;
    @(negedge clk);
    req_data[2*N +: N] = 8'h99; req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '1;
    total++; if (p_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_setup got=%b exp=1", p_valid); end
    #2 rstn = 1'b0;
    #1;
    total++; if (p_valid !== 1'b0)  begin bad++; $display("FAIL rst_mid_p_valid got=%b exp=0", p_valid); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    total++; if (req_ready !== '0)  begin bad++; $display("FAIL rst_mid_req_ready got=%b exp=0000", req_ready); end
    @(negedge clk);
    rstn = 1'b1; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_mid_next got=%b exp=0001", req_ready); end
    req_valid = '0; tb_ready = 1'b1;
    @(negedge clk);
  endtask

  // mode 1: serializer attached; mode 0: random p_ready stalls
  task automatic test_random(input logic mode);
    int           cnt_w[M];
    int           hd[M];
    logic [N-1:0] words[M][6];
    int           exp_id[$];
    int           got_id[$];
    int           pending, p, sel, cyc, n, g;
    apply_reset();
    ser_mode = mode;
    acc_q.delete(); ser_q.delete(); exp_q.delete();
    pending = 0;
    for (int i = 0; i < M; i++) begin
      cnt_w[i] = $urandom_range(1, 5);
      pending += cnt_w[i];
      hd[i] = 0;
      for (int j = 0; j < 6; j++) words[i][j] = N'($urandom);
    end
    // reference: with every queue presenting its head continuously, grants rotate
    // from the slot after the previous winner to the next non-empty queue
    p = 0;
    for (int r = 0; r < pending; r++) begin
      sel = -1;
      for (int k = 0; k < M; k++)
        if (sel < 0 && hd[(p + k) % M] < cnt_w[(p + k) % M]) sel = (p + k) % M;
      exp_id.push_back(sel);
      add_exp(sel, words[sel][hd[sel]]);
      hd[sel]++;
      p = (sel + 1) % M;
    end
    for (int i = 0; i < M; i++) hd[i] = 0;
    cyc = 0;
    while (pending > 0 && cyc < 3000) begin
      @(negedge clk); cyc++;
      for (int i = 0; i < M; i++) begin
        req_valid[i] = (hd[i] < cnt_w[i]);
        if (hd[i] < cnt_w[i]) req_data[i*N +: N] = words[i][hd[i]];
        else req_data[i*N +: N] = N'($urandom);
      end
      if (!mode) tb_ready = 1'($urandom_range(0, 1));
      #1;
      if (req_ready != '0) begin
        total++;
        if (!$onehot(req_ready) || (req_ready & ~req_valid) != '0) begin
          bad++; $display("FAIL rand_ready_shape got=%b valid=%b", req_ready, req_valid);
        end
        g = oh_idx(req_ready);
        got_id.push_back(g);
        hd[g]++;
        pending--;
      end
    end
    @(negedge clk);
    req_valid = '0; tb_ready = 1'b1;
    n = 0;
    while (((mode ? ser_q.size() : acc_q.size()) < exp_q.size() || busy) && n < 400) begin
      @(negedge clk); n++;
    end
    total++; if (cyc >= 3000 || n >= 400) begin bad++; $display("FAIL rand_timeout mode=%0d cyc=%0d drain=%0d", mode, cyc, n); end
    total++; if (got_id.size() != exp_id.size()) begin bad++; $display("FAIL rand_grants got=%0d exp=%0d", got_id.size(), exp_id.size()); end
    else for (int i = 0; i < exp_id.size(); i++) begin
      total++; if (got_id[i] != exp_id[i]) begin bad++; $display("FAIL rand_grant%0d got=%0d exp=%0d", i, got_id[i], exp_id[i]); end
    end
    if (mode) begin
      total++; if (ser_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_ser_count got=%0d exp=%0d", ser_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (ser_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_ser_word%0d got=%h exp=%h", i, ser_q[i], exp_q[i]); end
      end
    end else begin
      total++; if (acc_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_acc_count got=%0d exp=%0d", acc_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (acc_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_acc_word%0d got=%h exp=%h", i, acc_q[i], exp_q[i]); end
      end
    end
    ser_mode = 1'b0;
  endtask

  initial begin
    ser_mode = 1'b0; tb_ready = 1'b0; req_valid = '0; req_data = '0;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_mid_send();
    test_random(1'b1);
    test_random(1'b0);
    test_random(1'b1);
    test_random(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
